// File: rtl/config_shift_driver.sv
// config_shift_driver
//
// Serialises host configuration words onto a tile column's configuration
// shift chain. Words arrive over a valid/ready handshake and are shifted
// LSB-first on shift_out. shift_enable is high only on cycles carrying a
// real chain bit. After exactly CHAIN_LEN bits, set_hard pulses for one
// cycle so every tile latches its new configuration. done then pulses for
// one cycle.
//
// Optional feature macro: CONFIG_READBACK_EN
//   When defined, the chain's far-end output (chain_return) is captured on
//   every shift cycle. The captured bits are packed LSB-first into
//   readback_data, with one readback_valid strobe per word. This recovers the
//   previously loaded configuration, in load order.
//
// Parameters
//   WORD_W     host word width
//   CHAIN_LEN  total number of bits in the attached chain (>= 1)
//
// Ports
//   clk            clock, all state on the rising edge
//   rst            asynchronous active-low reset
//   start          begin a load (honoured only while idle)
//   word_valid     host word present
//   word_data      host word, bit 0 shifted first
//   word_ready     driver accepts a word this cycle
//   busy           load in progress
//   done           one-cycle pulse when a load completes
//   shift_enable   chain advance enable
//   shift_out      chain serial data (to shift_in_hard)
//   set_hard       one-cycle chain latch pulse
//   chain_return   chain serial output        (readback build only)
//   readback_data  returned word, LSB-first   (readback build only)
//   readback_valid one-cycle returned-word strobe (readback build only)

module config_shift_driver #(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              word_valid,
  input  logic [WORD_W-1:0] word_data,
  output logic              word_ready,
  output logic              busy,
  output logic              done,
  output logic              shift_enable,
  output logic              shift_out,
  output logic              set_hard
`ifdef CONFIG_READBACK_EN
  ,
  input  logic              chain_return,
  output logic [WORD_W-1:0] readback_data,
  output logic              readback_valid
`endif
);

  localparam int N_WORDS   = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int LAST_BITS = CHAIN_LEN - (N_WORDS - 1) * WORD_W;
  localparam int BC_W      = $clog2(WORD_W + 1);
  localparam int WC_W      = $clog2(N_WORDS + 1);

  // Bit-counter values at which a full word / the final partial word ends.
  localparam logic [BC_W-1:0] FULL_LAST  = BC_W'(WORD_W - 1);
  localparam logic [BC_W-1:0] TAIL_LAST  = BC_W'(LAST_BITS - 1);
  localparam logic [WC_W-1:0] FINAL_WORD = WC_W'(N_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_SET   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state, state_next;
  logic [WORD_W-1:0] shreg, shreg_next;
  logic [BC_W-1:0]   bit_cnt, bit_cnt_next;
  logic [WC_W-1:0]   word_cnt, word_cnt_next;
  logic              last_bit;

  // Final shift cycle of the current word; the last word may be truncated.
  always_comb begin
    if (word_cnt == FINAL_WORD) begin
      last_bit = (bit_cnt == TAIL_LAST);
    end else begin
      last_bit = (bit_cnt == FULL_LAST);
    end
  end

  // Next-state, shift-register and counter logic.
  always_comb begin
    state_next    = state;
    shreg_next    = shreg;
    bit_cnt_next  = bit_cnt;
    word_cnt_next = word_cnt;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next    = S_LOAD;
          bit_cnt_next  = '0;
          word_cnt_next = '0;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_LOAD: begin
        // word_ready is high throughout LOAD, so valid alone is a handshake.
        if (word_valid) begin
          shreg_next = word_data;
          state_next = S_SHIFT;
        end else begin
          state_next = S_LOAD;
        end
      end
      S_SHIFT: begin
        shreg_next = shreg >> 1'b1;
        if (last_bit) begin
          bit_cnt_next  = '0;
          word_cnt_next = word_cnt + 1'b1;
          if (word_cnt == FINAL_WORD) begin
            state_next = S_SET;
          end else begin
            state_next = S_LOAD;
          end
        end else begin
          bit_cnt_next = bit_cnt + 1'b1;
        end
      end
      S_SET:   state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // State, datapath and registered outputs (decoded from the next state so
  // that each output is aligned with the state it describes).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      shreg        <= '0;
      bit_cnt      <= '0;
      word_cnt     <= '0;
      word_ready   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      shift_enable <= 1'b0;
      shift_out    <= 1'b0;
      set_hard     <= 1'b0;
    end else begin
      state        <= state_next;
      shreg        <= shreg_next;
      bit_cnt      <= bit_cnt_next;
      word_cnt     <= word_cnt_next;
      word_ready   <= (state_next == S_LOAD);
      busy         <= (state_next != S_IDLE);
      done         <= (state_next == S_DONE);
      shift_enable <= (state_next == S_SHIFT);
      shift_out    <= (state_next == S_SHIFT) & shreg_next[0];
      set_hard     <= (state_next == S_SET);
    end
  end

`ifdef CONFIG_READBACK_EN
  logic [WORD_W-1:0] rb_acc;
  logic [WORD_W-1:0] rb_bit;

  // The returning bit lands at the same position as the outgoing bit.
  assign rb_bit = WORD_W'(chain_return) << bit_cnt;

  // Pack returned bits; the accumulator is cleared after each word, so bits
  // above LAST_BITS in the final word stay zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rb_acc         <= '0;
      readback_data  <= '0;
      readback_valid <= 1'b0;
    end else if (state == S_SHIFT) begin
      if (last_bit) begin
        readback_data  <= rb_acc | rb_bit;
        rb_acc         <= '0;
        readback_valid <= 1'b1;
      end else begin
        rb_acc         <= rb_acc | rb_bit;
        readback_valid <= 1'b0;
      end
    end else begin
      readback_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_config_shift_driver.sv
// Self-checking bench for config_shift_driver (WORD_W=8, CHAIN_LEN=20:
// three words, the last one truncated to 4 bits). A behavioural chain model
// receives the serial stream. Expected streams, cycle counts and readback
// words come from the word list and the host's own stall decisions.
module tb_config_shift_driver;

  localparam int WORD_W    = 8;
  localparam int CHAIN_LEN = 20;
  localparam int N_WORDS   = (CHAIN_LEN + WORD_W - 1) / WORD_W;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              word_valid = 1'b0;
  logic [WORD_W-1:0] word_data = '0;
  logic              word_ready, busy, done, shift_enable, shift_out, set_hard;
`ifdef CONFIG_READBACK_EN
  logic              chain_return;
  logic [WORD_W-1:0] readback_data;
  logic              readback_valid;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  config_shift_driver #(.WORD_W(WORD_W), .CHAIN_LEN(CHAIN_LEN)) dut (
    .clk(clk), .rst(rst), .start(start), .word_valid(word_valid),
    .word_data(word_data), .word_ready(word_ready), .busy(busy), .done(done),
    .shift_enable(shift_enable), .shift_out(shift_out), .set_hard(set_hard)
`ifdef CONFIG_READBACK_EN
    , .chain_return(chain_return), .readback_data(readback_data),
    .readback_valid(readback_valid)
`endif
  );

  // Chain model: new bits enter at the head (top index), and index 0 is the
  // far end that drives chain_return.
  logic [CHAIN_LEN-1:0] chain;
  always @(posedge clk) begin
    if (shift_enable) chain <= {shift_out, chain[CHAIN_LEN-1:1]};
  end
`ifdef CONFIG_READBACK_EN
  assign chain_return = chain[0];
`endif

  // Stimulus for the current load and the observations collected from it.
  logic [WORD_W-1:0]    cur_w  [N_WORDS];
  int                   cur_st [N_WORDS];
  bit                   cur_poke;
  logic [CHAIN_LEN-1:0] got_stream;
  logic [WORD_W-1:0]    rb_got [N_WORDS];
  int n_shift, n_set, set_cyc, done_cyc, n_overlap, n_busy, n_rb;
  bit timed_out, rdy1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one load cycle-by-cycle: sample at negedge, drive for the coming posedge.
  task automatic run_load();
    int wi = 0;
    int stall = cur_st[0];
    n_shift = 0; n_set = 0; set_cyc = -1; done_cyc = -1;
    n_overlap = 0; n_busy = 0; n_rb = 0; timed_out = 1'b1; rdy1 = 1'b0;
    got_stream = '0;
    @(negedge clk);
    start = 1'b1;
    word_valid = 1'($urandom_range(0, 1));
    word_data = WORD_W'($urandom());
    for (int c = 1; c < 300; c++) begin
      @(negedge clk);
      start = (cur_poke && busy && (c % 5 == 2)) ? 1'b1 : 1'b0;
      if (c == 1) rdy1 = word_ready;
      if (busy) n_busy++;
      if (shift_enable) begin
        if (n_shift < CHAIN_LEN) got_stream[n_shift] = shift_out;
        n_shift++;
      end
      if (set_hard) begin n_set++; set_cyc = c; end
      if (set_hard && shift_enable) n_overlap++;
`ifdef CONFIG_READBACK_EN
      if (readback_valid) begin
        if (n_rb < N_WORDS) rb_got[n_rb] = readback_data;
        n_rb++;
      end
`endif
      if (word_ready && wi < N_WORDS) begin
        if (stall > 0) begin
          word_valid = 1'b0;
          word_data = WORD_W'($urandom());
          stall--;
        end else begin
          word_valid = 1'b1;
          word_data = cur_w[wi];
          wi++;
          stall = (wi < N_WORDS) ? cur_st[wi] : 0;
        end
      end else begin
        // Junk outside LOAD must never be accepted.
        word_valid = 1'($urandom_range(0, 1));
        word_data = WORD_W'($urandom());
      end
      if (done) begin
        done_cyc = c;
        timed_out = 1'b0;
        break;
      end
    end
    start = 1'b0;
    word_valid = 1'b0;
  endtask

  task automatic load_and_check(input string name);
    logic [CHAIN_LEN-1:0] exp_stream;
    logic [CHAIN_LEN-1:0] prev;
    logic [WORD_W-1:0]    rb_exp;
    int exp_set = 1 + N_WORDS + CHAIN_LEN;
    prev = chain;
    for (int i = 0; i < CHAIN_LEN; i++) exp_stream[i] = cur_w[i / WORD_W][i % WORD_W];
    for (int j = 0; j < N_WORDS; j++) exp_set += cur_st[j];
    run_load();
    chk({name, "_timeout"}, 64'(timed_out), 64'd0);
    chk({name, "_ready_t1"}, 64'(rdy1), 64'd1);
    chk({name, "_nshift"}, 64'(n_shift), 64'(CHAIN_LEN));
    chk({name, "_stream"}, 64'(got_stream), 64'(exp_stream));
    chk({name, "_chain"}, 64'(chain), 64'(exp_stream));
    chk({name, "_nset"}, 64'(n_set), 64'd1);
    chk({name, "_set_cyc"}, 64'(set_cyc), 64'(exp_set));
    chk({name, "_done_cyc"}, 64'(done_cyc), 64'(exp_set + 1));
    chk({name, "_overlap"}, 64'(n_overlap), 64'd0);
    chk({name, "_busy_cyc"}, 64'(n_busy), 64'(exp_set + 1));
`ifdef CONFIG_READBACK_EN
    chk({name, "_nrb"}, 64'(n_rb), 64'(N_WORDS));
    for (int j = 0; j < N_WORDS; j++) begin
      rb_exp = '0;
      for (int b = 0; b < WORD_W; b++) begin
        if (j * WORD_W + b < CHAIN_LEN) rb_exp[b] = prev[j * WORD_W + b];
      end
      chk($sformatf("%s_rb%0d", name, j), 64'(rb_got[j]), 64'(rb_exp));
    end
`endif
    @(negedge clk);
    chk({name, "_idle_after"}, 64'({busy, done, word_ready, shift_enable, set_hard}), 64'd0);
  endtask

  initial begin
    chain = CHAIN_LEN'($urandom());

    // Reset state.
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({word_ready, busy, done, shift_enable, shift_out, set_hard}), 64'd0);
`ifdef CONFIG_READBACK_EN
    chk("reset_readback", 64'({readback_data, readback_valid}), 64'd0);
`endif
    rst = 1'b1;
    @(negedge clk);

    // Directed words, host always valid.
    cur_w[0] = 8'hA5; cur_w[1] = 8'h3C; cur_w[2] = 8'hF9;
    for (int j = 0; j < N_WORDS; j++) cur_st[j] = 0;
    cur_poke = 1'b0;
    load_and_check("dir");

    // Five-cycle host stall between words 1 and 2, with start pokes while busy.
    for (int j = 0; j < N_WORDS; j++) cur_w[j] = WORD_W'($urandom());
    cur_st[0] = 0; cur_st[1] = 5; cur_st[2] = 0;
    cur_poke = 1'b1;
    load_and_check("stall5");

    // Reset asserted mid-shift of word 2.
    @(negedge clk);
    start = 1'b1; word_valid = 1'b1; word_data = WORD_W'($urandom());
    n_shift = 0;
    for (int c = 1; c < 200 && n_shift < WORD_W + 3; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (shift_enable) n_shift++;
      word_data = WORD_W'($urandom());
    end
    chk("rst_reach_shift", 64'(n_shift), 64'(WORD_W + 3));
    rst = 1'b0;
    #1;
    chk("rst_mid_outputs", 64'({word_ready, busy, done, shift_enable, shift_out, set_hard}), 64'd0);
    word_valid = 1'b0;
    n_set = 0;
    repeat (2) begin @(negedge clk); if (set_hard) n_set++; end
    rst = 1'b1;
    repeat (4) begin @(negedge clk); if (set_hard || busy) n_set++; end
    chk("rst_no_set", 64'(n_set), 64'd0);

    // Randomised loads with random stalls and random start pokes.
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < N_WORDS; j++) begin
        cur_w[j] = WORD_W'($urandom());
        cur_st[j] = $urandom_range(0, 4);
      end
      cur_poke = 1'($urandom_range(0, 1));
      load_and_check($sformatf("rnd%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
